// File: rtl/imem_loadable.sv
// Loadable LEGv8 instruction memory: registered one-cycle fetch port plus a
// byte-serial, little-endian boot-load port writing a contiguous block of words.
module imem_loadable #(
  parameter int SIZE   = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  output logic [SIZE-1:0]   q,
  output logic              q_valid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_count,
  input  logic [7:0]        ld_byte,
  input  logic              ld_byte_valid,
  output logic              ld_byte_ready,
  output logic              ld_busy,
  output logic              ld_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = SIZE / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOAD = 1'b1;

  // Array starts zeroed from the configuration image; reset never touches it.
  logic [SIZE-1:0]   mem_r [DEPTH] = '{default: '0};

  logic [0:0]        state_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [ADDR_W:0]   words_left_r;
  logic [IDX_W-1:0]  byte_idx_r;
  logic [SIZE-1:0]   word_buf_r;
  logic [SIZE-1:0]   q_r;
  logic              q_valid_r;
  logic              ld_done_r;

  logic              byte_acc_s;
  logic              last_byte_s;
  logic              last_word_s;
  logic              fetch_s;
  logic              start_s;
  logic              zero_start_s;
  logic [SIZE-1:0]   word_next_s;

  assign byte_acc_s   = (state_r == LOAD) && ld_byte_valid;
  assign last_byte_s  = byte_acc_s && (byte_idx_r == IDX_W'(NB - 1));
  assign last_word_s  = last_byte_s && (words_left_r == (ADDR_W + 1)'(1));
  assign fetch_s      = rd_en && (state_r == IDLE);
  assign start_s      = ld_start && (state_r == IDLE);
  assign zero_start_s = start_s && (ld_count == (ADDR_W + 1)'(0));

  // Merge the incoming byte into its little-endian lane of the word being built.
  always_comb begin
    word_next_s = word_buf_r;
    if (byte_acc_s) begin
      word_next_s[8*byte_idx_r +: 8] = ld_byte;
    end else begin
      word_next_s = word_buf_r;
    end
  end

  // Load sequencer: IDLE/LOAD control, write pointer, remaining-word count, byte lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      wr_addr_r    <= ADDR_W'(0);
      words_left_r <= (ADDR_W + 1)'(0);
      byte_idx_r   <= IDX_W'(0);
      word_buf_r   <= SIZE'(0);
      ld_done_r    <= 1'b0;
    end else begin
      ld_done_r <= zero_start_s | last_word_s;
      case (state_r)
        IDLE: begin
          if (start_s && !zero_start_s) begin
            state_r      <= LOAD;
            wr_addr_r    <= ld_base;
            words_left_r <= ld_count;
            byte_idx_r   <= IDX_W'(0);
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (byte_acc_s) begin
            word_buf_r <= word_next_s;
            if (last_byte_s) begin
              byte_idx_r   <= IDX_W'(0);
              wr_addr_r    <= wr_addr_r + ADDR_W'(1);
              words_left_r <= words_left_r - (ADDR_W + 1)'(1);
              state_r      <= last_word_s ? IDLE : LOAD;
            end else begin
              byte_idx_r <= byte_idx_r + IDX_W'(1);
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Word write on the final byte; the pointer wraps naturally at the array end.
  always_ff @(posedge clk) begin
    if (last_byte_s) begin
      mem_r[wr_addr_r] <= word_next_s;
    end
  end

  // Fetch port: only served while idle, q holds its value otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r       <= SIZE'(0);
      q_valid_r <= 1'b0;
    end else begin
      q_valid_r <= fetch_s;
      if (fetch_s) begin
        q_r <= mem_r[addr];
      end
    end
  end

  assign q             = q_r;
  assign q_valid       = q_valid_r;
  assign ld_busy       = (state_r == LOAD);
  assign ld_byte_ready = (state_r == LOAD);
  assign ld_done       = ld_done_r;

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: directed scenarios plus randomized loads
// checked against a word-level memory model.
module tb_imem_loadable;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  addr;
  logic        rd_en;
  logic [31:0] q;
  logic        q_valid;
  logic        ld_start;
  logic [5:0]  ld_base;
  logic [6:0]  ld_count;
  logic [7:0]  ld_byte;
  logic        ld_byte_valid;
  logic        ld_byte_ready;
  logic        ld_busy;
  logic        ld_done;

  int tests = 0;
  int fails = 0;

  logic [31:0] model_mem [64];
  logic [31:0] wbuf [128];
  logic [31:0] exp_q;

  imem_loadable #(.SIZE(32), .ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .q(q), .q_valid(q_valid),
    .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count), .ld_byte(ld_byte),
    .ld_byte_valid(ld_byte_valid), .ld_byte_ready(ld_byte_ready), .ld_busy(ld_busy),
    .ld_done(ld_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single fetch issued at a negedge, checked one cycle later.
  task automatic fetch(input logic [5:0] a);
    rd_en = 1'b1;
    addr  = a;
    @(negedge clk);
    rd_en = 1'b0;
    exp_q = model_mem[a];
    check("fetch_valid", {31'd0, q_valid}, 32'd1);
    check("fetch_data", q, exp_q);
  endtask

  // Back-to-back fetches, one word per cycle.
  task automatic fetch_burst(input logic [5:0] a0, input int n);
    logic [5:0] ai;
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      ai   = a0 + 6'(i);
      addr = ai;
      @(negedge clk);
      exp_q = model_mem[ai];
      check("burst_valid", {31'd0, q_valid}, 32'd1);
      check("burst_data", q, exp_q);
    end
    rd_en = 1'b0;
    @(negedge clk);
    check("burst_idle_valid", {31'd0, q_valid}, 32'd0);
    check("burst_hold", q, exp_q);
  endtask

  // Loads count words from wbuf[] at base; stall_at inserts a 3-cycle gap before that byte.
  task automatic do_load(input logic [5:0] base, input logic [6:0] count, input int gap_pct,
                         input int stall_at, input bit interfere);
    int nbytes;
    int gap;
    logic [5:0] wa;
    logic [5:0] last_a;
    last_a   = base;
    ld_base  = base;
    ld_count = count;
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    if (count == 7'd0) begin
      check("zero_done", {31'd0, ld_done}, 32'd1);
      check("zero_busy", {31'd0, ld_busy}, 32'd0);
      @(negedge clk);
      check("zero_done_end", {31'd0, ld_done}, 32'd0);
      check("zero_busy_end", {31'd0, ld_busy}, 32'd0);
      return;
    end
    check("start_busy", {31'd0, ld_busy}, 32'd1);
    check("start_ready", {31'd0, ld_byte_ready}, 32'd1);
    check("start_done", {31'd0, ld_done}, 32'd0);
    nbytes = 4 * int'(count);
    for (int b = 0; b < nbytes; b++) begin
      if (b == stall_at) gap = 3;
      else if (int'($urandom_range(99)) < gap_pct) gap = int'($urandom_range(3, 1));
      else gap = 0;
      repeat (gap) begin
        @(negedge clk);
        check("stall_busy", {31'd0, ld_busy}, 32'd1);
        check("stall_done", {31'd0, ld_done}, 32'd0);
      end
      ld_byte_valid = 1'b1;
      ld_byte       = wbuf[b / 4][8 * (b % 4) +: 8];
      if (interfere) begin
        rd_en    = 1'b1;
        addr     = 6'h0E;
        ld_start = 1'b1;
        ld_base  = base ^ 6'h15;
        ld_count = 7'd3;
      end
      @(negedge clk);
      ld_byte_valid = 1'b0;
      rd_en         = 1'b0;
      ld_start      = 1'b0;
      if (interfere) begin
        check("intf_q_valid", {31'd0, q_valid}, 32'd0);
        check("intf_q_hold", q, exp_q);
      end
      if (b % 4 == 3) begin
        wa            = base + 6'(b / 4);
        model_mem[wa] = wbuf[b / 4];
        last_a        = wa;
      end
      if (b == nbytes - 1) begin
        check("end_busy", {31'd0, ld_busy}, 32'd0);
        check("end_ready", {31'd0, ld_byte_ready}, 32'd0);
        check("end_done", {31'd0, ld_done}, 32'd1);
      end else begin
        check("mid_busy", {31'd0, ld_busy}, 32'd1);
        check("mid_done", {31'd0, ld_done}, 32'd0);
      end
    end
    // Fetch in the ld_done cycle must see the word just written.
    rd_en = 1'b1;
    addr  = last_a;
    @(negedge clk);
    rd_en = 1'b0;
    exp_q = model_mem[last_a];
    check("post_done_pulse", {31'd0, ld_done}, 32'd0);
    check("post_fetch_valid", {31'd0, q_valid}, 32'd1);
    check("post_fetch_data", q, exp_q);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    logic [6:0] cnt;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
    exp_q         = 32'd0;
    reset         = 1'b1;
    addr          = 6'd0;
    rd_en         = 1'b0;
    ld_start      = 1'b0;
    ld_base       = 6'd0;
    ld_count      = 7'd0;
    ld_byte       = 8'd0;
    ld_byte_valid = 1'b0;

    // Reset while idle
    repeat (2) @(negedge clk);
    check("rst_q", q, 32'd0);
    check("rst_q_valid", {31'd0, q_valid}, 32'd0);
    check("rst_busy", {31'd0, ld_busy}, 32'd0);
    check("rst_done", {31'd0, ld_done}, 32'd0);
    check("rst_ready", {31'd0, ld_byte_ready}, 32'd0);
    reset = 1'b0;
    fetch(6'h05);
    @(negedge clk);
    check("idle_q_valid", {31'd0, q_valid}, 32'd0);

    // Two words at 0x0E, back-to-back bytes ce 01 0e cb 4e 00 00 b4
    wbuf[0] = 32'hcb0e01ce;
    wbuf[1] = 32'hb400004e;
    do_load(6'h0E, 7'd2, 0, -1, 1'b0);
    fetch(6'h0E);
    check("known_w0", q, 32'hcb0e01ce);
    fetch(6'h0F);
    check("known_w1", q, 32'hb400004e);

    // Wrap past the top with a mid-word stall
    wbuf[0] = 32'h8b01000f;
    wbuf[1] = 32'hf803800f;
    do_load(6'h3F, 7'd2, 0, 2, 1'b0);
    fetch(6'h3F);
    check("wrap_w0", q, 32'h8b01000f);
    fetch(6'h00);
    check("wrap_w1", q, 32'hf803800f);

    // Zero-length load
    do_load(6'h20, 7'd0, 0, -1, 1'b0);

    // Fetch and restart attempts during a load
    fetch(6'h0E);
    wbuf[0] = 32'h11223344;
    wbuf[1] = 32'h55667788;
    do_load(6'h30, 7'd2, 0, -1, 1'b1);
    fetch_burst(6'h2D, 8);

    // Reset after the 3rd byte of word 2
    wbuf[0] = $urandom;
    wbuf[1] = $urandom;
    done_seen = 0;
    ld_base  = 6'h10;
    ld_count = 7'd2;
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    for (int b = 0; b < 7; b++) begin
      ld_byte_valid = 1'b1;
      ld_byte       = wbuf[b / 4][8 * (b % 4) +: 8];
      @(negedge clk);
      if (ld_done) done_seen++;
    end
    ld_byte_valid    = 1'b0;
    model_mem[6'h10] = wbuf[0];
    reset = 1'b1;
    #1;
    exp_q = 32'd0;
    check("midrst_busy", {31'd0, ld_busy}, 32'd0);
    check("midrst_ready", {31'd0, ld_byte_ready}, 32'd0);
    check("midrst_q", q, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_done_seen", done_seen, 32'd0);
    check("midrst_done", {31'd0, ld_done}, 32'd0);
    fetch(6'h10);
    fetch(6'h11);

    // Randomized loads with random stalls
    for (int t = 0; t < 12; t++) begin
      cnt = 7'($urandom_range(5, 1));
      for (int w = 0; w < 5; w++) wbuf[w] = $urandom;
      do_load(6'($urandom_range(63)), cnt, 30, -1, 1'b0);
      fetch(6'($urandom_range(63)));
    end

    // Oversized load wraps and overwrites its own first word
    for (int w = 0; w < 65; w++) wbuf[w] = $urandom;
    do_load(6'($urandom_range(63)), 7'd65, 5, -1, 1'b0);

    fetch_burst(6'h00, 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
